// File: rtl/ex_mem_elastic.sv
// ex_mem_elastic: EX/MEM stage register with valid/ready handshake, flush, optional skid entry
// and MEM/WB control decode of the held instruction.
module ex_mem_elastic #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] nI,
    input  logic [XLEN-1:0] nAO,
    input  logic [XLEN-1:0] nWD,
    input  logic [XLEN-1:0] nPC,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] I,
    output logic [XLEN-1:0] AO,
    output logic [XLEN-1:0] WD,
    output logic [XLEN-1:0] PC,
    output logic [2:0]      MemOp,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      occ
);
    localparam int W = 4 * XLEN;

    logic [W-1:0] in_d, main_d;
    logic         main_v, acc, drn;
    logic [5:0]   op, funct;

    assign in_d      = {nI, nAO, nWD, nPC};
    assign acc       = in_valid & in_ready;
    assign drn       = main_v & out_ready;
    assign out_valid = main_v;
    assign {I, AO, WD, PC} = main_d;

    generate
        if (SKID != 0) begin : g_skid
            logic         skid_v;
            logic [W-1:0] skid_d;
            // in_ready is the inverted skid flop, so out_ready never reaches it combinationally
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                    skid_v <= 1'b0;
                    skid_d <= '0;
                end else if (!main_v || drn) begin
                    main_v <= skid_v | acc;
                    main_d <= skid_v ? skid_d : (acc ? in_d : '0);
                    skid_v <= skid_v & acc;
                    skid_d <= (skid_v && acc) ? in_d : '0;
                end else if (acc) begin
                    skid_v <= 1'b1;
                    skid_d <= in_d;
                end
            end
            assign in_ready = ~skid_v;
            assign occ      = {1'b0, main_v} + {1'b0, skid_v};
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                end else if (acc) begin
                    main_v <= 1'b1;
                    main_d <= in_d;
                end else if (drn) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                end
            end
            assign in_ready = out_ready | ~main_v;
            assign occ      = {1'b0, main_v};
        end
    endgenerate

    assign op    = I[31:26];
    assign funct = I[5:0];

    always_comb begin
        MemOp    = 3'd0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        MemtoReg = 2'd0;
        case (op)
            6'b100000: begin mem_rd = 1'b1; MemtoReg = 2'd1; end
            6'b100100: begin MemOp = 3'd1; mem_rd = 1'b1; MemtoReg = 2'd1; end
            6'b100001: begin MemOp = 3'd2; mem_rd = 1'b1; MemtoReg = 2'd1; end
            6'b100101: begin MemOp = 3'd3; mem_rd = 1'b1; MemtoReg = 2'd1; end
            6'b100011: begin MemOp = 3'd4; mem_rd = 1'b1; MemtoReg = 2'd1; end
            6'b101000: begin MemOp = 3'd5; mem_wr = 1'b1; end
            6'b101001: begin MemOp = 3'd6; mem_wr = 1'b1; end
            6'b101011: begin MemOp = 3'd7; mem_wr = 1'b1; end
            6'b000011: MemtoReg = 2'd2;
            6'b000000: MemtoReg = (funct == 6'b001001) ? 2'd2 : 2'd0;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ex_mem_elastic.sv
// tb_ex_mem_elastic: checks a SKID=1 and a SKID=0 instance against a queue model of the stage.
module tb_ex_mem_elastic;
    typedef struct packed {
        logic [31:0] i, ao, wd, pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush;
    logic        iv[2], ir[2], ov[2], ordy[2], mrd[2], mwr[2];
    logic [31:0] ni[2], nao[2], nwd[2], npc[2], oi[2], oao[2], owd[2], opc[2];
    logic [2:0]  mop[2];
    logic [1:0]  m2r[2], occ[2];

    int   checks = 0, errors = 0;
    ent_t mq[2][2];
    int   cnt[2];
    bit   acc_m[2], drn_m[2];

    ex_mem_elastic #(.XLEN(32), .SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
        .nI(ni[0]), .nAO(nao[0]), .nWD(nwd[0]), .nPC(npc[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .I(oi[0]), .AO(oao[0]), .WD(owd[0]), .PC(opc[0]), .MemOp(mop[0]), .mem_rd(mrd[0]),
        .mem_wr(mwr[0]), .MemtoReg(m2r[0]), .occ(occ[0]));

    ex_mem_elastic #(.XLEN(32), .SKID(0)) u_single (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
        .nI(ni[1]), .nAO(nao[1]), .nWD(nwd[1]), .nPC(npc[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .I(oi[1]), .AO(oao[1]), .WD(owd[1]), .PC(opc[1]), .MemOp(mop[1]), .mem_rd(mrd[1]),
        .mem_wr(mwr[1]), .MemtoReg(m2r[1]), .occ(occ[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // {MemOp, mem_rd, mem_wr, MemtoReg} from the instruction mnemonic table
    function automatic logic [6:0] ref_dec(input logic [31:0] ins);
        case (ins[31:26])
            6'h20: return {3'd0, 2'b10, 2'd1};
            6'h24: return {3'd1, 2'b10, 2'd1};
            6'h21: return {3'd2, 2'b10, 2'd1};
            6'h25: return {3'd3, 2'b10, 2'd1};
            6'h23: return {3'd4, 2'b10, 2'd1};
            6'h28: return {3'd5, 2'b01, 2'd0};
            6'h29: return {3'd6, 2'b01, 2'd0};
            6'h2b: return {3'd7, 2'b01, 2'd0};
            6'h03: return {3'd0, 2'b00, 2'd2};
            6'h00: return (ins[5:0] == 6'h09) ? {3'd0, 2'b00, 2'd2} : 7'd0;
            default: return 7'd0;
        endcase
    endfunction

    task automatic drv(input int k, input logic v, input logic r, input logic [31:0] i,
                       input logic [31:0] ao, input logic [31:0] wd, input logic [31:0] pc);
        iv[k] = v; ordy[k] = r; ni[k] = i; nao[k] = ao; nwd[k] = wd; npc[k] = pc;
    endtask

    task automatic drv2(input logic v, input logic r, input logic [31:0] i,
                        input logic [31:0] ao, input logic [31:0] wd, input logic [31:0] pc);
        drv(0, v, r, i, ao, wd, pc);
        drv(1, v, r, i, ao, wd, pc);
    endtask

    // called just after a posedge with inputs set: check both DUTs, then advance the model
    task automatic cyc();
        #2;
        for (int k = 0; k < 2; k++) begin
            ent_t f;
            logic [6:0] d;
            logic er;
            f  = (cnt[k] > 0) ? mq[k][0] : '0;
            d  = ref_dec(f.i);
            er = (k == 0) ? (cnt[k] < 2) : (ordy[k] || cnt[k] == 0);
            chk($sformatf("in_ready%0d", k), {31'd0, ir[k]}, {31'd0, er});
            chk($sformatf("out_valid%0d", k), {31'd0, ov[k]}, {31'd0, cnt[k] > 0});
            chk($sformatf("occ%0d", k), {30'd0, occ[k]}, cnt[k]);
            chk($sformatf("I%0d", k), oi[k], f.i);
            chk($sformatf("AO%0d", k), oao[k], f.ao);
            chk($sformatf("WD%0d", k), owd[k], f.wd);
            chk($sformatf("PC%0d", k), opc[k], f.pc);
            chk($sformatf("dec%0d", k), {25'd0, mop[k], mrd[k], mwr[k], m2r[k]}, {25'd0, d});
            if (k == 1 && cnt[k] == 1)
                chk("single_ready_eq_out_ready", {31'd0, ir[1]}, {31'd0, ordy[1]});
            acc_m[k] = iv[k] && er;
            drn_m[k] = cnt[k] > 0 && ordy[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset || flush) begin
                cnt[k] = 0;
                acc_m[k] = 1'b0;
            end else begin
                if (drn_m[k]) begin
                    mq[k][0] = mq[k][1];
                    cnt[k]--;
                end
                if (acc_m[k]) begin
                    mq[k][cnt[k]] = '{ni[k], nao[k], nwd[k], npc[k]};
                    cnt[k]++;
                end
            end
        end
        #1;
    endtask

    logic [31:0] pool[12];
    logic [31:0] pc_n[2];

    initial begin
        pool = '{32'h80000000, 32'h90000000, 32'h84000000, 32'h94000000, 32'h8C000000, 32'hA0000000,
                 32'hA4000000, 32'hAC000000, 32'h0C000000, 32'h00000009, 32'h00000000, 32'h54000000};
        cnt[0] = 0; cnt[1] = 0;
        reset = 1'b1; flush = 1'b0;
        drv2(1'b1, 1'b1, 32'h8C430004, 32'h11, 32'h22, 32'h1000);
        @(posedge clk); #1;
        cyc(); cyc();
        reset = 1'b0;
        drv2(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("rst_I", oi[0], 32'd0);
        chk("rst_PC", opc[0], 32'd0);
        chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
        chk("rst_occ", {30'd0, occ[0]}, 32'd0);

        drv2(1'b1, 1'b1, 32'h8C430004, 32'h00001004, 32'h0000AAAA, 32'h2000);
        cyc();
        chk("lw_I", oi[0], 32'h8C430004);
        chk("lw_MemOp", {29'd0, mop[0]}, 32'd4);
        chk("lw_mem_rd", {31'd0, mrd[0]}, 32'd1);
        chk("lw_MemtoReg", {30'd0, m2r[0]}, 32'd1);
        drv2(1'b1, 1'b1, 32'hAC430008, 32'h00001008, 32'h0000BBBB, 32'h2004);
        cyc();
        chk("sw_MemOp", {29'd0, mop[0]}, 32'd7);
        chk("sw_mem_wr", {31'd0, mwr[0]}, 32'd1);
        chk("sw_MemtoReg", {30'd0, m2r[0]}, 32'd0);
        drv2(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        cyc();

        drv2(1'b1, 1'b0, 32'h20000001, 32'h1, 32'h2, 32'h3000);
        cyc();
        drv2(1'b1, 1'b0, 32'h20000002, 32'h3, 32'h4, 32'h3004);
        cyc();
        drv2(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("skid_occ", {30'd0, occ[0]}, 32'd2);
        chk("skid_in_ready", {31'd0, ir[0]}, 32'd0);
        chk("skid_PC_a", opc[0], 32'h3000);
        drv2(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        cyc();
        chk("skid_PC_b", opc[0], 32'h3004);
        chk("skid_ready_back", {31'd0, ir[0]}, 32'd1);
        cyc();
        chk("skid_drained", {31'd0, ov[0]}, 32'd0);

        drv2(1'b1, 1'b0, 32'h20000003, 32'h5, 32'h6, 32'h3010);
        cyc();
        drv2(1'b1, 1'b0, 32'h20000004, 32'h7, 32'h8, 32'h3014);
        cyc();
        flush = 1'b1;
        drv2(1'b1, 1'b0, 32'h20000005, 32'h9, 32'hA, 32'h3008);
        cyc();
        flush = 1'b0;
        drv2(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("flush_occ", {30'd0, occ[0]}, 32'd0);
        chk("flush_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("flush_PC", opc[0], 32'd0);
        cyc();
        chk("flush_dropped", {31'd0, ov[0]}, 32'd0);

        drv2(1'b1, 1'b1, 32'h0C000C00, 32'h0, 32'h0, 32'h4000);
        cyc();
        chk("jal_MemtoReg", {30'd0, m2r[0]}, 32'd2);
        chk("jal_ctrl", {28'd0, mop[0], mrd[0]}, 32'd0);
        drv2(1'b1, 1'b1, 32'h03E0F809, 32'h0, 32'h0, 32'h4004);
        cyc();
        chk("jalr_MemtoReg", {30'd0, m2r[0]}, 32'd2);
        chk("jalr_ctrl", {28'd0, mop[0], mwr[0]}, 32'd0);
        drv2(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        cyc();

        pc_n[0] = 32'h5000; pc_n[1] = 32'h6000;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = pool[$urandom_range(11)] | ($urandom & 32'h03FFFFC0);
            drv(0, 1'($urandom), 1'($urandom), r, $urandom, $urandom, pc_n[0]);
            drv(1, 1'b1, 1'(n & 1), r, $urandom, $urandom, pc_n[1]);
            flush = ($urandom_range(39) == 0);
            cyc();
            for (int k = 0; k < 2; k++)
                if (acc_m[k]) pc_n[k] += 32'd4;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_elastic.md
Name: ex_mem_elastic

Overview:
- Parametrised EX/MEM pipeline stage with a valid/ready handshake, flush, and an optional 2-entry skid buffer. Sits between the EX stage (ALU/branch) and the MEM stage (DM access).
- Carries instruction, ALU output, store data and PC.
- Decodes the held instruction into memory-op and writeback-select controls for MEM/WB.
- Replaces the fixed always-load stage register, so stalls propagate without combinational ready chains.

Parameters:
- XLEN, 32, width of each of the I/AO/WD/PC payload fields.
- SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single entry (in_ready = out_ready | ~out_valid, combinational).

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- flush  input  1  discard all held entries (branch/exception kill)
- in_valid  input  1  EX presents a valid instruction
- in_ready  output  1  stage can accept this cycle
- nI  input  XLEN  instruction from EX
- nAO  input  XLEN  ALU result from EX
- nWD  input  XLEN  forwarded store data from EX
- nPC  input  XLEN  PC from EX
- out_valid  output  1  main entry holds a valid instruction
- out_ready  input  1  MEM consumes the main entry this cycle
- I  output  XLEN  held instruction (0 when out_valid=0)
- AO  output  XLEN  held ALU result (0 when out_valid=0)
- WD  output  XLEN  held store data (0 when out_valid=0)
- PC  output  XLEN  held PC (0 when out_valid=0)
- MemOp  output  3  lb0 lbu1 lh2 lhu3 lw4 sb5 sh6 sw7; 0 otherwise
- mem_rd  output  1  instruction is a load
- mem_wr  output  1  instruction is a store
- MemtoReg  output  2  1 = load, 2 = jal/jalr, 0 = otherwise
- occ  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- State: main entry (valid + 4 payload fields) and, if SKID=1, skid entry (valid + payload).
  - Outputs I/AO/WD/PC/out_valid come from the main entry only.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - Payload changes only on posedge.
- SKID=1:
  - in_ready = ~skid_valid, driven from a register with no combinational path from out_ready.
  - Main empty, or drain: main <= skid if skid valid, else incoming (if accept), else empty. When main loads from skid, skid <= incoming if accept, else empty.
  - Main full, no drain, accept: skid <= incoming; main holds.
  - Main full, no drain, no accept: hold everything.
- SKID=0:
  - in_ready = out_ready | ~out_valid.
  - Main <= incoming on accept; becomes empty on drain without accept.
- Ordering: strictly FIFO; no entry is lost or duplicated.
- Empty entry payload is all zeros (bubble = sll $0,$0,0, a nop), so downstream decode is safe without checking valid.
- reset or flush (same cycle priority, over everything):
  - Both entries invalid, payloads 0; a same-cycle input is dropped.
  - in_ready = 1 in the next cycle.
  - After reset, all outputs are 0 except in_ready=1.
- Decode (combinational from I, op = I[31:26], funct = I[5:0]):
  - Loads: lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011 → mem_rd=1, MemtoReg=1.
  - Stores: sb 101000, sh 101001, sw 101011 → mem_wr=1.
  - jal (op 000011) and jalr (op 0, funct 001001) → MemtoReg=2.
  - I=0 → MemOp 0, mem_rd 0, mem_wr 0, MemtoReg 0.
- occ = main_valid + skid_valid.
- Throughput: 1 instruction/cycle sustained while out_ready=1; latency 1 cycle from accept to out_valid.

Test Plan:
- Reset held 2 cycles with in_valid=1 → out_valid=0, I=AO=WD=PC=0, in_ready=1, occ=0.
- Stream: nI=0x8C430004 (lw), nAO=0x00001004, then nI=0xAC430008 (sw), out_ready=1 → cycle 1: I=0x8C430004, MemOp=4, mem_rd=1, MemtoReg=1; cycle 2: MemOp=7, mem_wr=1, MemtoReg=0.
- SKID=1, out_ready=0, feed A=PC 0x3000 then B=PC 0x3004 → occ=2, in_ready=0, PC=0x3000. Raise out_ready → PC=0x3000, then 0x3004, in order, with in_ready back to 1.
- flush with occ=2 while in_valid=1 (PC 0x3008) → next cycle occ=0, out_valid=0, PC=0; entry 0x3008 never appears.
- jal nI=0x0C000C00, then jalr nI=0x03E0F809 → MemtoReg=2 for both; MemOp=0, mem_rd=mem_wr=0.
- SKID=0, out_ready toggled 1/0 each cycle with in_valid=1 → in_ready equals out_ready whenever occ=1; the PC sequence is gap-free and duplicate-free.
